// File: rtl/regfile_scoreboard.sv
// Register file with a busy-bit scoreboard for long-latency producers.
// Optional same-cycle writeback forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 16,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic            I_regwen,
  input  logic [AW-1:0]   I_rd,
  input  logic [XLEN-1:0] I_data,
  input  logic [AW-1:0]   I_rs1,
  input  logic [AW-1:0]   I_rs2,
  output logic [XLEN-1:0] O_data1,
  output logic [XLEN-1:0] O_data2,
  input  logic            I_issue,
  input  logic [AW-1:0]   I_issue_rd,
  output logic            O_busy1,
  output logic            O_busy2,
  output logic            O_stall,
  output logic [AW:0]     O_pending
);

  localparam int unsigned PW = AW + 1;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [PW-1:0]    pending_q, pending_d;

  logic fwd1_c, fwd2_c;
  logic busy1_c, busy2_c, waw_c, stall_c, issue_go_c;

  // Same-cycle forwarding of the writeback onto the read ports
  always_comb begin
    fwd1_c = 1'b0;
    fwd2_c = 1'b0;
`ifdef REGFILE_BYPASS_EN
    fwd1_c = !I_rst && I_regwen && (I_rd == I_rs1) && (I_rs1 != '0);
    fwd2_c = !I_rst && I_regwen && (I_rd == I_rs2) && (I_rs2 != '0);
`endif
  end

  // Read ports, busy lookups and hazard detection
  always_comb begin
    O_data1 = '0;
    O_data2 = '0;
    if (fwd1_c)              O_data1 = I_data;
    else if (I_rs1 != '0)    O_data1 = regs_q[I_rs1];
    if (fwd2_c)              O_data2 = I_data;
    else if (I_rs2 != '0)    O_data2 = regs_q[I_rs2];
    busy1_c = (I_rs1 != '0) && busy_q[I_rs1] && !fwd1_c;
    busy2_c = (I_rs2 != '0) && busy_q[I_rs2] && !fwd2_c;
    waw_c   = I_issue && (I_issue_rd != '0) && busy_q[I_issue_rd];
    stall_c = busy1_c || busy2_c || waw_c;
  end

  assign O_busy1   = busy1_c;
  assign O_busy2   = busy2_c;
  assign O_stall   = stall_c;
  assign O_pending = pending_q;

  // Next register and scoreboard state; a same-register issue keeps the bit set
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    issue_go_c = I_issue && !stall_c && (I_issue_rd != '0);
    if (I_regwen && (I_rd != '0)) begin
      regs_d[I_rd] = I_data;
      if (!(I_issue && (I_issue_rd == I_rd))) busy_d[I_rd] = 1'b0;
    end
    if (issue_go_c) busy_d[I_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    regs_d[0] = '0;
    pending_d = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      pending_d = pending_d + PW'(busy_d[i]);
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (32-register build) against an
// array-based reference model; honours REGFILE_BYPASS_EN when defined.
module tb_regfile_scoreboard;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);
  localparam int unsigned PW    = AW + 1;

  logic            I_clk = 1'b0;
  logic            I_rst;
  logic            I_regwen;
  logic [AW-1:0]   I_rd;
  logic [XLEN-1:0] I_data;
  logic [AW-1:0]   I_rs1, I_rs2;
  logic [XLEN-1:0] O_data1, O_data2;
  logic            I_issue;
  logic [AW-1:0]   I_issue_rd;
  logic            O_busy1, O_busy2, O_stall;
  logic [AW:0]     O_pending;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              m_pend;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_regwen(I_regwen), .I_rd(I_rd),
    .I_data(I_data), .I_rs1(I_rs1), .I_rs2(I_rs2), .O_data1(O_data1),
    .O_data2(O_data2), .I_issue(I_issue), .I_issue_rd(I_issue_rd),
    .O_busy1(O_busy1), .O_busy2(O_busy2), .O_stall(O_stall),
    .O_pending(O_pending)
  );

  always #5 I_clk = ~I_clk;

  // ---------------- reference model ----------------
  function automatic bit fwd(input logic [AW-1:0] rs);
`ifdef REGFILE_BYPASS_EN
    return I_regwen && (rs != 0) && (I_rd == rs);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [XLEN-1:0] m_data(input logic [AW-1:0] rs);
    if (rs == 0) return '0;
    if (fwd(rs)) return I_data;
    return m_regs[rs];
  endfunction

  function automatic bit m_busyf(input logic [AW-1:0] rs);
    if (rs == 0 || fwd(rs)) return 1'b0;
    return m_busy[rs];
  endfunction

  function automatic bit m_stall();
    return m_busyf(I_rs1) || m_busyf(I_rs2) ||
           (I_issue && (I_issue_rd != 0) && m_busy[I_issue_rd]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREGS); i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_pend = 0;
  endtask

  task automatic model_commit();
    bit st;
    bit hold;
    st   = m_stall();
    hold = I_issue && (I_issue_rd == I_rd);
    if (I_regwen && I_rd != 0) begin
      m_regs[I_rd] = I_data;
      if (m_busy[I_rd] && !hold) begin
        m_busy[I_rd] = 1'b0;
        m_pend--;
      end
    end
    if (I_issue && !st && I_issue_rd != 0 && !m_busy[I_issue_rd]) begin
      m_busy[I_issue_rd] = 1'b1;
      m_pend++;
    end
  endtask

  task automatic idle();
    I_regwen = 0; I_rd = '0; I_data = '0; I_rs1 = '0; I_rs2 = '0;
    I_issue = 0; I_issue_rd = '0;
  endtask

  // Clock edge: DUT and model advance together; returns just after the edge
  task automatic step();
    @(posedge I_clk);
    model_commit();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    I_rst = 1; idle();
    I_rs1 = 5; I_rs2 = 3; I_regwen = 1; I_rd = 5; I_data = 32'hCAFE_F00D;
    I_issue = 1; I_issue_rd = 7;
    repeat (2) @(posedge I_clk);
    @(negedge I_clk);
    checks++; if (O_data1 !== '0) begin errors++; $display("FAIL reset_data1: got %0h want 0", O_data1); end
    checks++; if (O_stall !== 1'b0 || O_busy1 !== 1'b0 || O_busy2 !== 1'b0) begin errors++; $display("FAIL reset_flags: stall=%0b busy1=%0b busy2=%0b want 0", O_stall, O_busy1, O_busy2); end
    checks++; if (O_pending !== '0) begin errors++; $display("FAIL reset_pending: got %0d want 0", O_pending); end
    @(posedge I_clk); #1;
    I_rst = 0; model_reset(); idle(); I_rs1 = 5;
    @(negedge I_clk);
    checks++; if (O_data1 !== '0 || O_pending !== '0) begin errors++; $display("FAIL reset_discard: data1=%0h pending=%0d want 0", O_data1, O_pending); end
    step();
  endtask

  task automatic test_x0();
    idle(); I_regwen = 1; I_rd = 0; I_data = 32'hFFFF_FFFF; I_issue = 1; I_issue_rd = 0;
    @(negedge I_clk);
    checks++; if (O_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0b want 0", O_stall); end
    step();
    idle();
    @(negedge I_clk);
    checks++; if (O_data1 !== '0) begin errors++; $display("FAIL x0_data: got %0h want 0", O_data1); end
    checks++; if (O_pending !== '0 || O_stall !== 1'b0) begin errors++; $display("FAIL x0_pending: pending=%0d stall=%0b want 0 0", O_pending, O_stall); end
    step();
  endtask

  task automatic test_load_use();
    idle(); I_issue = 1; I_issue_rd = 3;
    step();
    idle(); I_rs1 = 3;
    @(negedge I_clk);
    checks++; if (O_busy1 !== 1'b1 || O_stall !== 1'b1) begin errors++; $display("FAIL lu_busy: busy1=%0b stall=%0b want 1 1", O_busy1, O_stall); end
    checks++; if (O_pending !== PW'(1)) begin errors++; $display("FAIL lu_pending: got %0d want 1", O_pending); end
    step();
    I_regwen = 1; I_rd = 3; I_data = 32'h1234_5678;
    @(negedge I_clk);
`ifdef REGFILE_BYPASS_EN
    checks++; if (O_data1 !== 32'h1234_5678 || O_stall !== 1'b0 || O_busy1 !== 1'b0) begin errors++; $display("FAIL lu_bypass: data1=%0h stall=%0b busy1=%0b want 12345678 0 0", O_data1, O_stall, O_busy1); end
`else
    checks++; if (O_data1 !== 32'h0 || O_stall !== 1'b1 || O_busy1 !== 1'b1) begin errors++; $display("FAIL lu_nobypass: data1=%0h stall=%0b busy1=%0b want 0 1 1", O_data1, O_stall, O_busy1); end
`endif
    step();
    idle(); I_rs1 = 3;
    @(negedge I_clk);
    checks++; if (O_data1 !== 32'h1234_5678 || O_stall !== 1'b0 || O_pending !== '0) begin errors++; $display("FAIL lu_after: data1=%0h stall=%0b pending=%0d want 12345678 0 0", O_data1, O_stall, O_pending); end
    step();
  endtask

  task automatic test_simul_issue_wb();
    idle(); I_issue = 1; I_issue_rd = 4;
    step();
    I_regwen = 1; I_rd = 4; I_data = 32'hA5A5_0F0F;
    @(negedge I_clk);
    checks++; if (O_stall !== 1'b1) begin errors++; $display("FAIL simul_stall: got %0b want 1", O_stall); end
    step();
    idle(); I_rs1 = 4;
    @(negedge I_clk);
    checks++; if (O_busy1 !== 1'b1 || O_pending !== PW'(1)) begin errors++; $display("FAIL simul_busy: busy1=%0b pending=%0d want 1 1", O_busy1, O_pending); end
    checks++; if (O_data1 !== 32'hA5A5_0F0F) begin errors++; $display("FAIL simul_data: got %0h want a5a50f0f", O_data1); end
    I_regwen = 1; I_rd = 4; I_rs1 = 0;
    step();
    idle();
    @(negedge I_clk);
    checks++; if (O_pending !== '0) begin errors++; $display("FAIL simul_clear: got %0d want 0", O_pending); end
    step();
  endtask

  task automatic test_waw();
    idle(); I_issue = 1; I_issue_rd = 6;
    step();
    @(negedge I_clk);
    checks++; if (O_stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %0b want 1", O_stall); end
    step();
    idle(); I_rs2 = 6;
    @(negedge I_clk);
    checks++; if (O_pending !== PW'(1) || O_busy2 !== 1'b1) begin errors++; $display("FAIL waw_pending: pending=%0d busy2=%0b want 1 1", O_pending, O_busy2); end
    I_rs2 = 0; I_regwen = 1; I_rd = 6;
    step();
    idle();
    @(negedge I_clk);
    checks++; if (O_pending !== '0) begin errors++; $display("FAIL waw_clear: got %0d want 0", O_pending); end
    step();
  endtask

  task automatic test_fill();
    for (int r = 1; r < int'(NREGS); r++) begin
      idle(); I_issue = 1; I_issue_rd = AW'(r);
      @(negedge I_clk);
      checks++; if (O_stall !== 1'b0 || O_pending !== PW'(r - 1)) begin errors++; $display("FAIL fill_issue r=%0d: stall=%0b pending=%0d want 0 %0d", r, O_stall, O_pending, r - 1); end
      step();
    end
    idle();
    @(negedge I_clk);
    checks++; if (O_pending !== PW'(NREGS - 1)) begin errors++; $display("FAIL fill_full: got %0d want %0d", O_pending, NREGS - 1); end
    for (int r = 1; r < int'(NREGS); r++) begin
      idle(); I_regwen = 1; I_rd = AW'(r); I_data = 32'h0101_0101 * r;
      step();
    end
    idle(); I_rs1 = 31; I_rs2 = 17;
    @(negedge I_clk);
    checks++; if (O_pending !== '0) begin errors++; $display("FAIL fill_empty: got %0d want 0", O_pending); end
    checks++; if (O_data1 !== 32'h1F1F_1F1F || O_data2 !== 32'h1111_1111) begin errors++; $display("FAIL fill_data: d1=%0h d2=%0h want 1f1f1f1f 11111111", O_data1, O_data2); end
    step();
  endtask

  task automatic test_reset_mid_op();
    idle(); I_regwen = 1; I_rd = 5; I_data = 32'hDEAD_BEEF;
    step();
    idle(); I_issue = 1; I_issue_rd = 7;
    step();
    idle(); I_rs1 = 5;
    @(negedge I_clk);
    checks++; if (O_data1 !== 32'hDEAD_BEEF || O_pending !== PW'(1)) begin errors++; $display("FAIL rmo_pre: data1=%0h pending=%0d want deadbeef 1", O_data1, O_pending); end
    #2 I_rst = 1;
    #1;
    checks++; if (O_data1 !== '0 || O_pending !== '0 || O_stall !== 1'b0) begin errors++; $display("FAIL rmo_async: data1=%0h pending=%0d stall=%0b want 0 0 0", O_data1, O_pending, O_stall); end
    model_reset();
    @(posedge I_clk); #1;
    I_rst = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int hi;
      hi = (n % 3 == 0) ? int'(NREGS) - 1 : 7;
      I_regwen   = ($urandom_range(0, 99) < 45);
      I_rd       = AW'($urandom_range(0, hi));
      I_data     = $urandom;
      I_issue    = ($urandom_range(0, 99) < 45);
      I_issue_rd = AW'($urandom_range(0, hi));
      I_rs1      = AW'($urandom_range(0, hi));
      I_rs2      = AW'($urandom_range(0, hi));
      @(negedge I_clk);
      checks++; if (O_data1 !== m_data(I_rs1) || O_data2 !== m_data(I_rs2)) begin errors++; $display("FAIL rnd_data n=%0d: d1=%0h d2=%0h want %0h %0h", n, O_data1, O_data2, m_data(I_rs1), m_data(I_rs2)); end
      checks++; if (O_busy1 !== m_busyf(I_rs1) || O_busy2 !== m_busyf(I_rs2)) begin errors++; $display("FAIL rnd_busy n=%0d: b1=%0b b2=%0b want %0b %0b", n, O_busy1, O_busy2, m_busyf(I_rs1), m_busyf(I_rs2)); end
      checks++; if (O_stall !== m_stall()) begin errors++; $display("FAIL rnd_stall n=%0d: got %0b want %0b", n, O_stall, m_stall()); end
      checks++; if (O_pending !== PW'(m_pend)) begin errors++; $display("FAIL rnd_pending n=%0d: got %0d want %0d", n, O_pending, m_pend); end
      step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_x0();
    test_load_use();
    test_simul_issue_wb();
    test_waw();
    test_fill();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
